// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: selects the next PC from sequential,
// redirect, trap-vector or exception-return sources, with stall, halt and trap capture.
module pc_sequencer #(
   parameter int unsigned      XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'('h100),
   parameter int unsigned      IALIGN       = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            trap_req,
   input  logic            mret,
   input  logic            halt_req,
   input  logic            resume,
   output logic [XLEN-1:0] pc_current,
   output logic [XLEN-1:0] pc_plus,
   output logic            pc_valid,
   output logic            halted,
   output logic [XLEN-1:0] epc,
   output logic            trap_cause,
   output logic            trap_taken,
   output logic [XLEN-1:0] retire_count
);

   // state | meaning
   // BOOT  | single cycle after reset release, PC held, no fetch
   // RUN   | fetching; one PC source applied per unstalled edge
   // HALT  | fetch suspended, waiting for resume
   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
   localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic            cause_q, cause_d;
   logic            trap_taken_q, trap_taken_d;
   logic [XLEN-1:0] retire_q, retire_d;
   logic            misaligned;

   assign pc_plus    = pc_q + STEP;
   assign misaligned = (br_target & ALIGN_MASK) != '0;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      epc_d        = epc_q;
      cause_d      = cause_q;
      trap_taken_d = 1'b0;
      retire_d     = retire_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (!stall) begin
               if (trap_req) begin
                  pc_d         = TRAP_VECTOR;
                  epc_d        = pc_q;
                  cause_d      = 1'b1;
                  trap_taken_d = 1'b1;
               end else if (br_taken && misaligned) begin
                  pc_d         = TRAP_VECTOR;
                  epc_d        = pc_q;
                  cause_d      = 1'b0;
                  trap_taken_d = 1'b1;
               end else begin
                  retire_d = retire_q + XLEN'(1);
                  if (mret)          pc_d = epc_q;
                  else if (br_taken) pc_d = br_target;
                  else               pc_d = pc_plus;
               end
               if (halt_req) state_d = ST_HALT;
            end
         end
         // The held PC becomes the first fetch after resume.
         ST_HALT: if (resume) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_VECTOR;
         epc_q        <= '0;
         cause_q      <= 1'b0;
         trap_taken_q <= 1'b0;
         retire_q     <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         epc_q        <= epc_d;
         cause_q      <= cause_d;
         trap_taken_q <= trap_taken_d;
         retire_q     <= retire_d;
      end
   end

   assign pc_current   = pc_q;
   assign pc_valid     = (state_q == ST_RUN);
   assign halted       = (state_q == ST_HALT);
   assign epc          = epc_q;
   assign trap_cause   = cause_q;
   assign trap_taken   = trap_taken_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, redirect, priority, stall, halt, wrap,
// plus a compressed-alignment (IALIGN=2) instance.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n, stall, br_taken, trap_req, mret, halt_req, resume;
   logic [31:0] br_target;
   logic [31:0] pc_current, pc_plus, epc, retire_count;
   logic        pc_valid, halted, trap_cause, trap_taken;

   logic        reset_n2, br_taken2;
   logic [31:0] br_target2;
   logic [31:0] pc_current2, pc_plus2, epc2, retire_count2;
   logic        pc_valid2, halted2, trap_cause2, trap_taken2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(4)) u_dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
      .trap_req(trap_req), .mret(mret), .halt_req(halt_req), .resume(resume),
      .pc_current(pc_current), .pc_plus(pc_plus), .pc_valid(pc_valid), .halted(halted),
      .epc(epc), .trap_cause(trap_cause), .trap_taken(trap_taken), .retire_count(retire_count)
   );

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n2), .stall(1'b0), .br_taken(br_taken2), .br_target(br_target2),
      .trap_req(1'b0), .mret(1'b0), .halt_req(1'b0), .resume(1'b0),
      .pc_current(pc_current2), .pc_plus(pc_plus2), .pc_valid(pc_valid2), .halted(halted2),
      .epc(epc2), .trap_cause(trap_cause2), .trap_taken(trap_taken2), .retire_count(retire_count2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_core(input string tag, input logic [31:0] pc, input logic [31:0] rc,
                           input logic valid, input logic hlt);
      chk({tag, ".pc"},     pc_current,   pc);
      chk({tag, ".retire"}, retire_count, rc);
      chk({tag, ".valid"},  {31'b0, pc_valid}, {31'b0, valid});
      chk({tag, ".halted"}, {31'b0, halted},   {31'b0, hlt});
   endtask

   task automatic clr_req();
      stall = 0; br_taken = 0; br_target = '0; trap_req = 0; mret = 0; halt_req = 0; resume = 0;
   endtask

   initial begin
      reset_n = 0; reset_n2 = 0; br_taken2 = 0; br_target2 = '0;
      clr_req();
      #12;
      chk_core("rst", 32'h0, 32'h0, 1'b0, 1'b0);
      chk("rst.epc", epc, 32'h0);
      chk("rst.cause", {31'b0, trap_cause}, 32'h0);
      chk("rst.ttaken", {31'b0, trap_taken}, 32'h0);
      chk("rst.pcplus", pc_plus, 32'h4);

      // BOOT cycle, then sequential fetch
      reset_n = 1;
      chk_core("boot", 32'h0, 32'h0, 1'b0, 1'b0);
      step(); chk_core("run0", 32'h0, 32'h0, 1'b1, 1'b0);
      step(); chk_core("run1", 32'h4, 32'h1, 1'b1, 1'b0);
      step(); chk_core("run2", 32'h8, 32'h2, 1'b1, 1'b0);

      // T5 halt
      halt_req = 1;
      step(); chk_core("halt", 32'hC, 32'h3, 1'b0, 1'b1);
      clr_req(); br_taken = 1; br_target = 32'h200; trap_req = 1; mret = 1; stall = 1;
      step(); chk_core("halt.ign", 32'hC, 32'h3, 1'b0, 1'b1);
      chk("halt.ttaken", {31'b0, trap_taken}, 32'h0);
      chk("halt.epc", epc, 32'h0);
      clr_req(); resume = 1;
      step(); chk_core("resume", 32'hC, 32'h3, 1'b1, 1'b0);
      clr_req();
      step(); chk_core("resume.seq", 32'h10, 32'h4, 1'b1, 1'b0);

      // T2 redirect and misaligned target
      br_taken = 1; br_target = 32'h200;
      step(); chk_core("br", 32'h200, 32'h5, 1'b1, 1'b0);
      br_target = 32'h10;
      step(); chk_core("br.back", 32'h10, 32'h6, 1'b1, 1'b0);
      br_target = 32'h202;
      step(); chk_core("mis", 32'h100, 32'h6, 1'b1, 1'b0);
      chk("mis.epc", epc, 32'h10);
      chk("mis.cause", {31'b0, trap_cause}, 32'h0);
      chk("mis.ttaken", {31'b0, trap_taken}, 32'h1);
      clr_req();
      step(); chk_core("mis.after", 32'h104, 32'h7, 1'b1, 1'b0);
      chk("mis.pulse", {31'b0, trap_taken}, 32'h0);

      // T3 priority: trap beats misaligned-free redirect and mret
      br_taken = 1; br_target = 32'h30;
      step(); chk_core("pri.pre", 32'h30, 32'h8, 1'b1, 1'b0);
      br_target = 32'h200; trap_req = 1; mret = 1;
      step(); chk_core("pri", 32'h100, 32'h8, 1'b1, 1'b0);
      chk("pri.epc", epc, 32'h30);
      chk("pri.cause", {31'b0, trap_cause}, 32'h1);
      chk("pri.ttaken", {31'b0, trap_taken}, 32'h1);
      clr_req(); mret = 1;
      step(); chk_core("mret", 32'h30, 32'h9, 1'b1, 1'b0);
      chk("mret.ttaken", {31'b0, trap_taken}, 32'h0);

      // T4 stall with redirect and halt held
      clr_req(); stall = 1; br_taken = 1; br_target = 32'h400; halt_req = 1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_core("stall", 32'h30, 32'h9, 1'b1, 1'b0);
      end
      stall = 0; halt_req = 0;
      step(); chk_core("unstall", 32'h400, 32'hA, 1'b1, 1'b0);

      // T6 wrap
      br_target = 32'hFFFF_FFFC;
      step(); chk_core("wrap.pre", 32'hFFFF_FFFC, 32'hB, 1'b1, 1'b0);
      chk("wrap.pcplus", pc_plus, 32'h0);
      clr_req();
      step(); chk_core("wrap", 32'h0, 32'hC, 1'b1, 1'b0);

      // T1 async reset mid-run at pc=0x40
      br_taken = 1; br_target = 32'h40;
      step(); chk_core("t1.pre", 32'h40, 32'hD, 1'b1, 1'b0);
      clr_req();
      #3 reset_n = 0;
      #1 chk_core("t1.async", 32'h0, 32'h0, 1'b0, 1'b0);
      chk("t1.epc", epc, 32'h0);
      step(); reset_n = 1;
      step(); chk_core("t1.boot", 32'h0, 32'h0, 1'b1, 1'b0);
      step(); chk_core("t1.seq1", 32'h4, 32'h1, 1'b1, 1'b0);
      step(); chk_core("t1.seq2", 32'h8, 32'h2, 1'b1, 1'b0);

      // IALIGN=2 instance
      reset_n2 = 1;
      step(); chk("ia2.boot", pc_current2, 32'h0);
      chk("ia2.pcplus", pc_plus2, 32'h2);
      br_taken2 = 1; br_target2 = 32'h2;
      step(); chk("ia2.al.pc", pc_current2, 32'h2);
      chk("ia2.al.tt", {31'b0, trap_taken2}, 32'h0);
      chk("ia2.al.rc", retire_count2, 32'h1);
      br_target2 = 32'h3;
      step(); chk("ia2.mis.pc", pc_current2, 32'h100);
      chk("ia2.mis.tt", {31'b0, trap_taken2}, 32'h1);
      chk("ia2.mis.epc", epc2, 32'h2);
      chk("ia2.mis.cause", {31'b0, trap_cause2}, 32'h0);
      br_taken2 = 0;
      step(); chk("ia2.seq", pc_current2, 32'h102);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
